// File: rtl/timer_apb_regs.sv
`default_nettype none
// ============================================================================
// Module   : timer_apb_regs
// Purpose  : APB slave register block for the 8-bit timer counter. Holds the
//            reload value (TDR) and control bits (TCR). Generates one-cycle
//            load / flag-clear strobes and returns the counter flags (TSR).
//            A wait-state FSM inserts WAIT_STATES cycles of pready low.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   i_psel, i_penable   APB select / access-phase enable
//   i_pwrite            1 = write, 0 = read
//   i_paddr, i_pwdata   register address / write data
//   o_prdata            read data (0x00 unless o_pready)
//   o_pready            transfer completion
//   o_pslverr           error response for out-of-map addresses
//   i_overflow          counter overflow flag (TSR[0])
//   i_underflow         counter underflow flag (TSR[1])
//   o_start_counter     reload value (TDR)
//   o_up_down, o_enable TCR[5], TCR[4]
//   o_cks               TCR[1:0] prescaler select
//   o_load              one-cycle load strobe
//   o_clr_overflow      one-cycle overflow clear strobe
//   o_clr_underflow     one-cycle underflow clear strobe
// ============================================================================
module timer_apb_regs #(
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_psel,
  input  logic              i_penable,
  input  logic              i_pwrite,
  input  logic [ADDR_W-1:0] i_paddr,
  input  logic [7:0]        i_pwdata,
  output logic [7:0]        o_prdata,
  output logic              o_pready,
  output logic              o_pslverr,
  input  logic              i_overflow,
  input  logic              i_underflow,
  output logic [7:0]        o_start_counter,
  output logic              o_up_down,
  output logic              o_enable,
  output logic [1:0]        o_cks,
  output logic              o_load,
  output logic              o_clr_overflow,
  output logic              o_clr_underflow
);

  localparam logic [0:0] c_IDLE   = 1'b0;
  localparam logic [0:0] c_ACCESS = 1'b1;

  localparam logic [3:0]        c_WAIT     = 4'(WAIT_STATES);
  localparam logic [ADDR_W-1:0] c_ADDR_TDR = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] c_ADDR_TCR = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] c_ADDR_TSR = ADDR_W'(2);

  logic [0:0] r_state;
  logic [3:0] r_wait;
  logic [7:0] r_tdr;
  logic       r_up_down;
  logic       r_enable;
  logic [1:0] r_cks;
  logic       r_load;
  logic       r_clr_ovf;
  logic       r_clr_unf;

  logic       w_ready;
  logic       w_complete;
  logic       w_hit_tdr;
  logic       w_hit_tcr;
  logic       w_hit_tsr;
  logic       w_err;
  logic       w_wr_tdr;
  logic       w_wr_tcr;
  logic       w_wr_tsr;
  logic [7:0] w_rdata;

  // pready decodes registered state only, so no APB input reaches it.
  assign w_ready    = (r_state == c_ACCESS) && (r_wait == 4'd0);
  assign w_complete = i_psel & i_penable & w_ready;

  assign w_hit_tdr = (i_paddr == c_ADDR_TDR);
  assign w_hit_tcr = (i_paddr == c_ADDR_TCR);
  assign w_hit_tsr = (i_paddr == c_ADDR_TSR);
  assign w_err     = ~(w_hit_tdr | w_hit_tcr | w_hit_tsr);

  assign w_wr_tdr = w_complete & i_pwrite & w_hit_tdr;
  assign w_wr_tcr = w_complete & i_pwrite & w_hit_tcr;
  assign w_wr_tsr = w_complete & i_pwrite & w_hit_tsr;

  always_comb begin
    w_rdata = 8'h00;
    if (w_hit_tdr) w_rdata = r_tdr;
    if (w_hit_tcr) w_rdata = {2'b00, r_up_down, r_enable, 2'b00, r_cks};
    if (w_hit_tsr) w_rdata = {6'b000000, i_underflow, i_overflow};
  end

  assign o_prdata  = w_ready ? w_rdata : 8'h00;
  assign o_pready  = w_ready;
  assign o_pslverr = w_ready & w_err;

  // Wait-state FSM. Dropping psel in ACCESS abandons the transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_wait  <= 4'd0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (i_psel && !i_penable) begin
            r_state <= c_ACCESS;
            r_wait  <= c_WAIT;
          end
        end
        c_ACCESS: begin
          if (!i_psel || w_complete) begin
            r_state <= c_IDLE;
            r_wait  <= 4'd0;
          end else if (r_wait != 4'd0) begin
            r_wait <= r_wait - 4'd1;
          end
        end
        default: begin
          r_state <= c_IDLE;
          r_wait  <= 4'd0;
        end
      endcase
    end
  end

  // Register file. The strobes are registered from the same completing
  // edge as the control bits, so load rises with the new TCR/TDR values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tdr     <= 8'h00;
      r_up_down <= 1'b0;
      r_enable  <= 1'b0;
      r_cks     <= 2'b00;
      r_load    <= 1'b0;
      r_clr_ovf <= 1'b0;
      r_clr_unf <= 1'b0;
    end else begin
      if (w_wr_tdr) r_tdr <= i_pwdata;
      if (w_wr_tcr) begin
        r_up_down <= i_pwdata[5];
        r_enable  <= i_pwdata[4];
        r_cks     <= i_pwdata[1:0];
      end
      r_load    <= w_wr_tcr & i_pwdata[7];
      // TSR bits are write-0-to-clear.
      r_clr_ovf <= w_wr_tsr & ~i_pwdata[0];
      r_clr_unf <= w_wr_tsr & ~i_pwdata[1];
    end
  end

  assign o_start_counter = r_tdr;
  assign o_up_down       = r_up_down;
  assign o_enable        = r_enable;
  assign o_cks           = r_cks;
  assign o_load          = r_load;
  assign o_clr_overflow  = r_clr_ovf;
  assign o_clr_underflow = r_clr_unf;

endmodule
`default_nettype wire

// File: tb/tb_timer_apb_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_apb_regs
// Purpose  : Directed self-checking bench for timer_apb_regs. Two instances:
//            u_dut2 (WAIT_STATES=2) and u_dut0 (WAIT_STATES=0) on one bus,
//            with psel steered by sel0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_apb_regs;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel0 = 1'b0;
  logic       psel = 1'b0;
  logic       penable = 1'b0;
  logic       pwrite = 1'b0;
  logic [7:0] paddr = 8'h00;
  logic [7:0] pwdata = 8'h00;
  logic       overflow = 1'b0;
  logic       underflow = 1'b0;

  logic [7:0] prdata2, prdata0, start2, start0;
  logic       pready2, pready0, pslverr2, pslverr0;
  logic       up2, up0, en2, en0, load2, load0;
  logic [1:0] cks2, cks0;
  logic       covf2, covf0, cunf2, cunf0;

  logic [7:0] w_prdata;
  logic       w_pready;
  logic       w_pslverr;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  timer_apb_regs #(.WAIT_STATES(2), .ADDR_W(8)) u_dut2 (
    .clk(clk), .rst(rst), .i_psel(psel & ~sel0), .i_penable(penable),
    .i_pwrite(pwrite), .i_paddr(paddr), .i_pwdata(pwdata),
    .o_prdata(prdata2), .o_pready(pready2), .o_pslverr(pslverr2),
    .i_overflow(overflow), .i_underflow(underflow),
    .o_start_counter(start2), .o_up_down(up2), .o_enable(en2), .o_cks(cks2),
    .o_load(load2), .o_clr_overflow(covf2), .o_clr_underflow(cunf2)
  );

  timer_apb_regs #(.WAIT_STATES(0), .ADDR_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .i_psel(psel & sel0), .i_penable(penable),
    .i_pwrite(pwrite), .i_paddr(paddr), .i_pwdata(pwdata),
    .o_prdata(prdata0), .o_pready(pready0), .o_pslverr(pslverr0),
    .i_overflow(overflow), .i_underflow(underflow),
    .o_start_counter(start0), .o_up_down(up0), .o_enable(en0), .o_cks(cks0),
    .o_load(load0), .o_clr_overflow(covf0), .o_clr_underflow(cunf0)
  );

  assign w_prdata  = sel0 ? prdata0  : prdata2;
  assign w_pready  = sel0 ? pready0  : pready2;
  assign w_pslverr = sel0 ? pslverr0 : pslverr2;

  // One APB transfer. Entered and left 1 time unit after a rising edge, so
  // consecutive calls form back-to-back transfers. waits counts access
  // cycles seen with pready low.
  task automatic apb(input logic s0, input logic wr, input logic [7:0] a,
                     input logic [7:0] d, output logic [7:0] rd,
                     output logic er, output int waits);
    logic done;
    done  = 1'b0;
    rd    = 8'hxx;
    er    = 1'bx;
    waits = 0;
    sel0 = s0; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (w_pready) begin
        rd = w_prdata; er = w_pslverr; done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk); #1;
    end
    psel = 1'b0; penable = 1'b0;
    if (!done) begin
      total++;
      $display("FAIL apb_timeout: got no pready, required pready within 40 cycles (addr %0h)", a);
    end
  endtask

  task automatic test_reset();
    #2;
    total++; if ({prdata2, pready2, pslverr2, start2, up2, en2, cks2, load2, covf2, cunf2} !== 25'd0)
      $display("FAIL reset_outputs: got %0h required 0", {prdata2, pready2, pslverr2, start2, up2, en2, cks2, load2, covf2, cunf2});
    else passed++;
    @(posedge clk); #1; rst = 1'b0;
    // Start TDR write of 0xAA, then hit reset in the middle of the wait.
    sel0 = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'hAA;
    @(posedge clk); #1; penable = 1'b1;
    @(posedge clk); #1; rst = 1'b1;
    #1;
    total++; if (pready2 !== 1'b0) $display("FAIL reset_mid_pready: got %0b required 0", pready2); else passed++;
    @(posedge clk); #1; psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    total++; if (start2 !== 8'h00) $display("FAIL reset_mid_tdr: got %0h required 00", start2); else passed++;
    total++; if (load2 !== 1'b0) $display("FAIL reset_mid_load: got %0b required 0", load2); else passed++;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    total++; if ({prdata2, pready2, pslverr2, start2, up2, en2, cks2, load2, covf2, cunf2} !== 25'd0)
      $display("FAIL reset_release: got %0h required 0", {prdata2, pready2, pslverr2, start2, up2, en2, cks2, load2, covf2, cunf2});
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    logic [7:0] rd; logic er; int w;
    apb(1'b0, 1'b1, 8'h00, 8'h5C, rd, er, w);
    total++; if (w !== 2) $display("FAIL wr_waits: got %0d required 2", w); else passed++;
    total++; if (er !== 1'b0) $display("FAIL wr_pslverr: got %0b required 0", er); else passed++;
    total++; if (start2 !== 8'h5C) $display("FAIL wr_start_counter: got %0h required 5c", start2); else passed++;
    apb(1'b0, 1'b0, 8'h00, 8'h00, rd, er, w);
    total++; if (rd !== 8'h5C) $display("FAIL rd_tdr: got %0h required 5c", rd); else passed++;
    total++; if (w !== 2) $display("FAIL rd_waits: got %0d required 2", w); else passed++;
  endtask

  task automatic test_control();
    logic [7:0] rd; logic er; int w;
    apb(1'b0, 1'b1, 8'h01, 8'hB2, rd, er, w);
    @(negedge clk);
    total++; if (load2 !== 1'b1) $display("FAIL tcr_load_high: got %0b required 1", load2); else passed++;
    total++; if ({up2, en2, cks2} !== 4'b1110) $display("FAIL tcr_bits: got %0b required 1110", {up2, en2, cks2}); else passed++;
    @(negedge clk);
    total++; if (load2 !== 1'b0) $display("FAIL tcr_load_one_cycle: got %0b required 0", load2); else passed++;
    @(posedge clk); #1;
    apb(1'b0, 1'b0, 8'h01, 8'h00, rd, er, w);
    total++; if (rd !== 8'h32) $display("FAIL tcr_read: got %0h required 32", rd); else passed++;
  endtask

  task automatic test_status();
    logic [7:0] rd; logic er; int w;
    overflow = 1'b1; underflow = 1'b1;
    apb(1'b0, 1'b0, 8'h02, 8'h00, rd, er, w);
    total++; if (rd !== 8'h03) $display("FAIL tsr_read_both: got %0h required 03", rd); else passed++;
    @(negedge clk);
    total++; if ({covf2, cunf2} !== 2'b00) $display("FAIL tsr_read_no_clear: got %0b required 00", {covf2, cunf2}); else passed++;
    @(posedge clk); #1;
    overflow = 1'b0;
    apb(1'b0, 1'b0, 8'h02, 8'h00, rd, er, w);
    total++; if (rd !== 8'h02) $display("FAIL tsr_read_live: got %0h required 02", rd); else passed++;
    apb(1'b0, 1'b1, 8'h02, 8'h02, rd, er, w);
    @(negedge clk);
    total++; if ({covf2, cunf2} !== 2'b10) $display("FAIL tsr_clr_ovf_only: got %0b required 10", {covf2, cunf2}); else passed++;
    @(negedge clk);
    total++; if ({covf2, cunf2} !== 2'b00) $display("FAIL tsr_clr_one_cycle: got %0b required 00", {covf2, cunf2}); else passed++;
    @(posedge clk); #1;
    apb(1'b0, 1'b1, 8'h02, 8'h00, rd, er, w);
    @(negedge clk);
    total++; if ({covf2, cunf2} !== 2'b11) $display("FAIL tsr_clr_both: got %0b required 11", {covf2, cunf2}); else passed++;
    @(posedge clk); #1;
    underflow = 1'b0;
  endtask

  task automatic test_errors();
    logic [7:0] rd; logic er; int w;
    apb(1'b0, 1'b1, 8'h07, 8'hFF, rd, er, w);
    total++; if (er !== 1'b1) $display("FAIL err_wr_pslverr: got %0b required 1", er); else passed++;
    total++; if (rd !== 8'h00) $display("FAIL err_wr_prdata: got %0h required 00", rd); else passed++;
    @(negedge clk);
    total++; if ({start2, up2, en2, cks2} !== {8'h5C, 4'b1110}) $display("FAIL err_no_state_change: got %0h required 5ce", {start2, up2, en2, cks2}); else passed++;
    total++; if ({load2, covf2, cunf2} !== 3'b000) $display("FAIL err_no_strobe: got %0b required 000", {load2, covf2, cunf2}); else passed++;
    @(posedge clk); #1;
    apb(1'b0, 1'b0, 8'h07, 8'h00, rd, er, w);
    total++; if ({er, rd} !== 9'h100) $display("FAIL err_rd: got %0h required 100", {er, rd}); else passed++;
    // Protocol abort: drop psel while the slave is still inserting waits.
    sel0 = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h11;
    @(posedge clk); #1; penable = 1'b1;
    @(posedge clk); #1; psel = 1'b0; penable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (pready2 !== 1'b0) $display("FAIL abort_pready: got %0b required 0", pready2); else passed++;
    total++; if (start2 !== 8'h5C) $display("FAIL abort_no_commit: got %0h required 5c", start2); else passed++;
    // A full wait sequence afterwards shows the FSM restarted from IDLE.
    apb(1'b0, 1'b0, 8'h00, 8'h00, rd, er, w);
    total++; if ({w[3:0], rd} !== {4'd2, 8'h5C}) $display("FAIL abort_recover: got %0h required 25c", {w[3:0], rd}); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd; logic er; int w1, w2; time t0;
    t0 = $time;
    apb(1'b1, 1'b1, 8'h00, 8'h3C, rd, er, w1);
    total++; if (start0 !== 8'h3C) $display("FAIL b2b_tdr_early: got %0h required 3c", start0); else passed++;
    apb(1'b1, 1'b1, 8'h01, 8'h80, rd, er, w2);
    total++; if ((w1 + w2) !== 0) $display("FAIL b2b_waits: got %0d required 0", w1 + w2); else passed++;
    total++; if (int'(($time - t0) / 10) !== 4) $display("FAIL b2b_cycles: got %0d required 4", int'(($time - t0) / 10)); else passed++;
    @(negedge clk);
    total++; if ({load0, start0} !== {1'b1, 8'h3C}) $display("FAIL b2b_load_with_tdr: got %0h required 13c", {load0, start0}); else passed++;
    total++; if ({up0, en0, cks0} !== 4'b0000) $display("FAIL b2b_tcr_bits: got %0b required 0000", {up0, en0, cks0}); else passed++;
    @(negedge clk);
    total++; if (load0 !== 1'b0) $display("FAIL b2b_load_one_cycle: got %0b required 0", load0); else passed++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_control();
    test_status();
    test_errors();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/timer_apb_regs.md
Name: timer_apb_regs

Overview:
- APB slave register block that sits directly upstream of the 8-bit timer counter and drives all of its control inputs.
- Holds the reload value and the control bits, and generates the one-cycle load and flag-clear strobes.
- Returns the counter's overflow/underflow flags on the status read path.
- Adds a wait-state FSM so bus timing can match the integration.

Parameters:
WAIT_STATES, 1, number of extra access-phase cycles with pready low before completion (0..15)
ADDR_W, 8, paddr width

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
psel  input  1  APB select
penable  input  1  APB enable (access phase)
pwrite  input  1  1 = write, 0 = read
paddr  input  ADDR_W  register address
pwdata  input  8  write data
prdata  output  8  read data, valid when pready=1
pready  output  1  transfer completion
pslverr  output  1  error response, valid when pready=1
overflow  input  1  counter overflow flag
underflow  input  1  counter underflow flag
start_counter  output  8  reload value (TDR)
up_down  output  1  TCR[5]
enable  output  1  TCR[4]
cks  output  2  TCR[1:0], prescaler select
load  output  1  one-cycle load strobe
clr_overflow  output  1  one-cycle clear strobe
clr_underflow  output  1  one-cycle clear strobe

Behaviour:
- Reset: the only reset is the asynchronous active-high rst.
  - While rst=1: FSM=IDLE, wait counter=0, TDR=0x00, TCR=0x00, and all outputs 0 (prdata, pready, pslverr, start_counter, up_down, enable, cks, load, clr_*).
  - Reset asserted mid-transfer aborts the transfer with no register update and no strobe.
- Register map:
  - 0x00 TDR: RW, 8 bits.
  - 0x01 TCR: bit7 LOAD (write-1 strobe, reads 0), bit5 up_down, bit4 enable, bits1:0 cks. Other bits write-ignored and read 0.
  - 0x02 TSR: bit1 underflow, bit0 overflow, read live. Writing 0 to a bit pulses the matching clr_*; writing 1 has no effect. Bits 7:2 read 0.
  - Any other address: pslverr=1, no state change, prdata=0x00.
- FSM states are IDLE and ACCESS.
  - IDLE -> ACCESS when psel=1 & penable=0 (setup phase); wait counter loads WAIT_STATES.
  - In ACCESS, the wait counter decrements while nonzero.
  - pready=1 exactly when state=ACCESS & counter=0. pready is a function of registered state only, with no combinational path from APB inputs.
  - Completion is psel & penable & pready. On completion the write commits at that clock edge and the FSM returns to IDLE.
  - A back-to-back setup phase in the cycle after completion is accepted normally.
  - psel=0 while in ACCESS (protocol abort): return to IDLE, no commit, no strobe.
- Read path:
  - prdata is a combinational mux of the addressed register, gated to 0x00 when pready=0.
  - TSR reads are side-effect free.
- Strobes: load, clr_overflow and clr_underflow are registered. Each is high exactly one cycle, in the cycle after the completing edge.
  - TCR write with bit7=1 updates up_down/enable/cks and pulses load in the same cycle those outputs change.
  - start_counter is TDR registered. A TDR write followed by a LOAD write presents the new value to the counter no later than the load strobe.
- A single TSR write of 0x00 pulses both clears in the same cycle.
- If a flag sets in the same cycle a clear strobe is high, the counter gives priority to clear. This block does not resample.
- WAIT_STATES=0 gives the minimal APB transfer: one setup cycle plus one access cycle.
- pslverr=1 only with pready=1 and an out-of-map address. Reads and writes are treated alike.

Test Plan:
- Reset: assert rst mid-ACCESS on a TDR write of 0xAA -> TDR stays 0x00, pready=0, no strobes; after release all outputs are 0.
- Write/read with WAIT_STATES=2: write TDR=0x5C -> pready low 2 access cycles then high 1 cycle; start_counter=0x5C; a read of 0x00 returns 0x5C on the pready cycle.
- Control: write TCR=0xB2 -> up_down=1, enable=1, cks=2'b10, load high exactly 1 cycle; a TCR read returns 0x32.
- Status: overflow=1, underflow=1 -> read TSR=0x03. Write 0x02 -> only clr_overflow pulses. Write 0x00 -> both pulse in the same cycle.
- Errors: access paddr=0x07 -> pslverr=1 with pready, prdata=0x00, no register or strobe change. Drop psel mid-wait -> FSM returns to IDLE, no commit.
- Back-to-back: WAIT_STATES=0, writes to TDR then TCR(LOAD) in consecutive transfers -> start_counter updates before or with the load pulse, and each transfer takes 2 cycles.
